// File: rtl/decode_field_pipe.sv
// -----------------------------------------------------------------------------
// decode_field_pipe
//
// Buffered decode-field stage between instruction fetch and control/regfile
// logic. Instruction words and their PCs are queued in a DEPTH-entry circular
// FIFO with a valid/ready handshake. The head entry is decoded
// combinationally into register indices, opcode, funct fields, an illegal
// flag and the sign-extended XLEN immediate selected by instruction format.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous reset, active-high (priority over flush)
//   flush      in   1     discard all queued entries at the next edge
//   in_valid   in   1     in_instr/in_pc valid
//   in_ready   out  1     buffer can accept (count != DEPTH)
//   in_instr   in   32    instruction word
//   in_pc      in   XLEN  instruction PC
//   out_valid  out  1     head entry valid (count != 0)
//   out_ready  in   1     consumer accepts head
//   out_pc     out  XLEN  head PC
//   A1/A2/A3   out  5     head rs1 / rs2 / rd fields
//   OP         out  7     head opcode
//   funct3     out  3     head instr[14:12]
//   funct7     out  7     head instr[31:25]
//   imm        out  XLEN  sign-extended immediate
//   illegal    out  1     head instr[1:0] != 2'b11
// All field outputs are forced to zero while out_valid is low.
// -----------------------------------------------------------------------------
module decode_field_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      A1,
    output logic [4:0]      A2,
    output logic [4:0]      A3,
    output logic [6:0]      OP,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OPIMMW = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate decode by format. Each format's raw field is assembled as a
    // signed vector; the size cast then sign-extends it to XLEN.
    function automatic logic [XLEN-1:0] decode_imm(input logic [31:0] ins);
        logic [XLEN-1:0] res;
        case (ins[6:0])
            OP_LOAD, OP_OPIMM, OP_OPIMMW, OP_JALR, OP_SYSTEM:
                res = XLEN'($signed(ins[31:20]));
            OP_STORE:
                res = XLEN'($signed({ins[31:25], ins[11:7]}));
            OP_BRANCH:
                res = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            OP_LUI, OP_AUIPC:
                res = XLEN'($signed({ins[31:12], 12'b0}));
            OP_JAL:
                res = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default:
                res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    logic [31:0]      instr_mem_r [DEPTH];
    logic [XLEN-1:0]  pc_mem_r    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             push_s;
    logic             pop_s;
    logic [31:0]      head_instr_s;
    logic [XLEN-1:0]  head_pc_s;

    // Handshake status derived directly from the occupancy count.
    always_comb begin
        in_ready  = (count_r != CNT_FULL);
        out_valid = (count_r != CNT_ZERO);
        push_s    = in_valid & in_ready & ~flush;
        pop_s     = out_valid & out_ready;
    end

    // Storage write; contents are only meaningful under the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= in_instr;
            pc_mem_r[wr_ptr_r]    <= in_pc;
        end
    end

    // Pointer and count update; reset outranks flush, both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry selection; an empty FIFO presents an all-zero word and PC.
    always_comb begin
        head_instr_s = 32'd0;
        head_pc_s    = {XLEN{1'b0}};
        if (out_valid) begin
            head_instr_s = instr_mem_r[rd_ptr_r];
            head_pc_s    = pc_mem_r[rd_ptr_r];
        end else begin
            head_instr_s = 32'd0;
            head_pc_s    = {XLEN{1'b0}};
        end
    end

    // Field extraction from the head word; a zero word yields zero fields.
    always_comb begin
        out_pc  = head_pc_s;
        A1      = head_instr_s[19:15];
        A2      = head_instr_s[24:20];
        A3      = head_instr_s[11:7];
        OP      = head_instr_s[6:0];
        funct3  = head_instr_s[14:12];
        funct7  = head_instr_s[31:25];
        imm     = decode_imm(head_instr_s);
        // Gated by out_valid because the zero word itself has low bits != 11.
        illegal = out_valid & (head_instr_s[1:0] != 2'b11);
    end

endmodule

// File: tb/tb_decode_field_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_field_pipe
//
// Self-checking bench for decode_field_pipe. A queue-based reference model
// tracks the FIFO contents; expected fields and immediates are computed from
// the instruction-format rules with plain arithmetic. Directed vectors cover
// the documented cases, followed by randomized traffic with flush and reset.
// -----------------------------------------------------------------------------
module tb_decode_field_pipe;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      A1;
    logic [4:0]      A2;
    logic [4:0]      A3;
    logic [6:0]      OP;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;

    int n_cmp;
    int n_err;
    bit model_known;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t q[$];

    decode_field_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .A1(A1), .A2(A2), .A3(A3), .OP(OP),
        .funct3(funct3), .funct7(funct7), .imm(imm), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate from the format rules: gather the raw field value as a number,
    // then sign-extend it arithmetically from its bit width.
    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        logic [6:0]      op;
        longint unsigned v;
        int              n;
        op = w[6:0];
        v  = 64'd0;
        n  = 0;
        if (op inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h73}) begin
            v = 64'(w[31:20]);
            n = 12;
        end else if (op == 7'h23) begin
            v = 64'(w[31:25]) * 64'd32 + 64'(w[11:7]);
            n = 12;
        end else if (op == 7'h63) begin
            v = 64'(w[31]) * 64'd4096 + 64'(w[7]) * 64'd2048
              + 64'(w[30:25]) * 64'd32 + 64'(w[11:8]) * 64'd2;
            n = 13;
        end else if (op == 7'h37 || op == 7'h17) begin
            v = 64'(w[31:12]) * 64'd4096;
            n = 32;
        end else if (op == 7'h6F) begin
            v = 64'(w[31]) * 64'd1048576 + 64'(w[19:12]) * 64'd4096
              + 64'(w[20]) * 64'd2048 + 64'(w[30:21]) * 64'd2;
            n = 21;
        end
        if (n > 0 && v >= (64'd1 << (n - 1))) begin
            v = v - (64'd1 << n);
        end
        return v;
    endfunction

    task automatic compare_all();
        logic [31:0] w;
        logic [63:0] p;
        bit          v;
        v = (q.size() != 0);
        w = v ? q[0].instr : 32'd0;
        p = v ? q[0].pc : 64'd0;
        check_val("in_ready",  64'(in_ready),  64'(q.size() != DEPTH));
        check_val("out_valid", 64'(out_valid), 64'(v));
        check_val("out_pc",    out_pc,         p);
        check_val("A1",        64'(A1),        64'((w >> 15) & 32'h1F));
        check_val("A2",        64'(A2),        64'((w >> 20) & 32'h1F));
        check_val("A3",        64'(A3),        64'((w >> 7) & 32'h1F));
        check_val("OP",        64'(OP),        64'(w & 32'h7F));
        check_val("funct3",    64'(funct3),    64'((w >> 12) & 32'h7));
        check_val("funct7",    64'(funct7),    64'(w >> 25));
        check_val("imm",       imm,            v ? ref_imm(w) : 64'd0);
        check_val("illegal",   64'(illegal),   64'(v && ((w & 32'h3) != 32'h3)));
    endtask

    // One clock cycle: drive, compare against the model, clock, update model.
    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                        input bit ordy, input bit fl, input bit r);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        #1;
        if (model_known) compare_all();
        do_push = v && (q.size() != DEPTH) && !fl;
        do_pop  = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (r || fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{instr: ins, pc: pc});
        end
        if (r) model_known = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12];
        logic [31:0] raw;
        int          k;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
        raw = $urandom;
        k   = $urandom_range(0, 13);
        if (k < 12) return {raw[31:7], ops[k]};
        if (k == 12) return 32'd0;
        return raw;
    endfunction

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        model_known = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 64'd0;

        step(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 1'b1);

        // addi x1,x2,-1
        step(1'b1, 32'hFFF10093, 64'h1000, 1'b0, 1'b0, 1'b0);
        check_val("addi_valid", 64'(out_valid), 64'd1);
        check_val("addi_A1",    64'(A1),        64'd2);
        check_val("addi_A3",    64'(A3),        64'd1);
        check_val("addi_OP",    64'(OP),        64'h13);
        check_val("addi_imm",   imm,            64'hFFFFFFFFFFFFFFFF);
        check_val("addi_pc",    out_pc,         64'h1000);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // sd x5,8(x10)
        step(1'b1, 32'h00553423, 64'h1004, 1'b0, 1'b0, 1'b0);
        check_val("sd_A1",  64'(A1),     64'd10);
        check_val("sd_A2",  64'(A2),     64'd5);
        check_val("sd_f3",  64'(funct3), 64'd3);
        check_val("sd_imm", imm,         64'd8);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // beq x0,x0,-4
        step(1'b1, 32'hFE000EE3, 64'h1008, 1'b0, 1'b0, 1'b0);
        check_val("beq_imm", imm, 64'hFFFFFFFFFFFFFFFC);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // lui x3,0x12345
        step(1'b1, 32'h123451B7, 64'h100C, 1'b0, 1'b0, 1'b0);
        check_val("lui_A3",  64'(A3), 64'd3);
        check_val("lui_imm", imm,     64'h0000000012345000);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // add (R-type)
        step(1'b1, 32'h00B50533, 64'h1010, 1'b0, 1'b0, 1'b0);
        check_val("add_imm", imm,         64'd0);
        check_val("add_f7",  64'(funct7), 64'd0);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Full / backpressure: third word must not be taken.
        step(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0, 1'b0);
        check_val("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0, 1'b0);
        check_val("full_head_pc", out_pc, 64'h2000);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check_val("drain_pc2", out_pc, 64'h2004);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check_val("drain_ready", 64'(in_ready), 64'd1);

        // count=1 with push and pop together: head advances to new word.
        step(1'b1, 32'h00400213, 64'h3000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00500293, 64'h3004, 1'b1, 1'b0, 1'b0);
        check_val("pp_pc",    out_pc,           64'h3004);
        check_val("pp_ready", 64'(in_ready),    64'd1);
        // count=DEPTH with pop: no push that cycle.
        step(1'b1, 32'h00600313, 64'h3008, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00700393, 64'h300C, 1'b1, 1'b0, 1'b0);
        check_val("fullpop_pc", out_pc, 64'h3008);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check_val("fullpop_empty", 64'(out_valid), 64'd0);

        // Flush with count=2 and an incoming word.
        step(1'b1, 32'h00800413, 64'h4000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00900493, 64'h4004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00A00513, 64'h4008, 1'b0, 1'b1, 1'b0);
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_pc",    out_pc,         64'd0);

        // Reset mid-stream.
        step(1'b1, 32'h00B00593, 64'h5000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00C00613, 64'h5004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00D00693, 64'h5008, 1'b0, 1'b0, 1'b1);
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_ready", 64'(in_ready),  64'd1);

        // All-zero word is illegal with a zero immediate.
        step(1'b1, 32'h00000000, 64'h6000, 1'b0, 1'b0, 1'b0);
        check_val("ill_valid", 64'(out_valid), 64'd1);
        check_val("ill_flag",  64'(illegal),   64'd1);
        check_val("ill_imm",   imm,            64'd0);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom};
            step(($urandom % 4) != 0, rand_instr(), rpc,
                 ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 150) == 0);
        end
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
